// File: rtl/hline_axi_arbiter.sv
// Round-robin arbiter sharing one AXI master port between NREQ
// horizontal-line z-buffer engines, with a burst watchdog.
module hline_axi_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_rd,
  input  logic [NREQ-1:0]   req_wr,
  input  logic [NREQ*32-1:0] req_addr,
  output logic [NREQ-1:0]   req_done,
  output logic              m_rd_req,
  output logic              m_wr_req,
  output logic [31:0]       m_addr,
  input  logic              m_done,
  output logic              grant_valid,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_err,
  output logic [IDW-1:0]    timeout_id,
  input  logic              err_clr
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_REL
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_owner;
  logic            r_dir_rd;
  logic [31:0]     r_addr;
  logic [31:0]     r_cnt;
  logic            r_terr;
  logic [IDW-1:0]  r_tid;

  logic [NREQ-1:0] w_req;
  logic            w_any;
  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  w_ptr_nx;
  logic            w_sel_rd;
  logic [31:0]     w_sel_addr;
  logic            w_busy;
  logic            w_done;
  logic            w_tmo;
  logic            w_grant;

  assign w_req = req_rd | req_wr;

  // Unrolled priority search starting at the RR pointer, wrapping.
  always_comb begin
    w_any      = 1'b0;
    w_sel      = '0;
    w_ptr_nx   = '0;
    w_sel_rd   = 1'b0;
    w_sel_addr = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (r_ptr == IDW'(j)) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!w_any && w_req[(j+k)%NREQ]) begin
            w_any      = 1'b1;
            w_sel      = IDW'((j+k)%NREQ);
            w_ptr_nx   = IDW'((j+k+1)%NREQ);
            w_sel_rd   = req_rd[(j+k)%NREQ];
            w_sel_addr = req_addr[32*((j+k)%NREQ) +: 32];
          end
        end
      end
    end
  end

  assign w_busy  = (r_state == ST_BUSY);
  assign w_done  = w_busy && m_done;
  assign w_grant = (r_state == ST_IDLE) && w_any;

  // m_done in the last allowed cycle still completes normally.
  assign w_tmo = w_busy && !m_done && (TIMEOUT != 0) &&
                 (r_cnt == 32'(TIMEOUT - 1));

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nx = ST_BUSY;
      end
      ST_BUSY: begin
        if (w_done || w_tmo) w_state_nx = ST_REL;
      end
      ST_REL: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr    <= '0;
      r_owner  <= '0;
      r_dir_rd <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_grant) begin
        r_owner  <= w_sel;
        r_dir_rd <= w_sel_rd;
        r_addr   <= w_sel_addr;
        r_ptr    <= w_ptr_nx;
      end
      if (w_busy && (w_state_nx == ST_BUSY)) begin
        r_cnt <= r_cnt + 32'd1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // A new timeout takes priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_terr <= 1'b0;
      r_tid  <= '0;
    end else if (w_tmo) begin
      r_terr <= 1'b1;
      r_tid  <= r_owner;
    end else if (err_clr) begin
      r_terr <= 1'b0;
    end
  end

  always_comb begin
    req_done = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_done[i] = w_done && (r_owner == IDW'(i));
    end
  end

  assign m_rd_req    = w_busy && r_dir_rd;
  assign m_wr_req    = w_busy && !r_dir_rd;
  assign m_addr      = w_busy ? r_addr : 32'd0;
  assign grant_valid = w_busy;
  assign grant_id    = r_owner;
  assign timeout_err = r_terr;
  assign timeout_id  = r_tid;

endmodule

// File: tb/tb_hline_axi_arbiter.sv
// Directed bench for hline_axi_arbiter: vector table plus
// hand-written round-robin and watchdog sequences.
module tb_hline_axi_arbiter;

  localparam logic [31:0] A1 = 32'h1111_0000;
  localparam logic [31:0] A2 = 32'h1000_0400;
  localparam logic [31:0] A3 = 32'h3333_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_rd;
  logic [3:0]  req_wr;
  logic [31:0] a0;
  logic [127:0] req_addr;
  logic [3:0]  req_done;
  logic        m_rd_req;
  logic        m_wr_req;
  logic [31:0] m_addr;
  logic        m_done;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        timeout_err;
  logic [1:0]  timeout_id;
  logic        err_clr;

  int n_vec = 0;
  int n_bad = 0;

  assign req_addr = {A3, A2, A1, a0};

  always #5 clk = ~clk;

  hline_axi_arbiter #(
    .NREQ(4), .IDW(2), .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_rd(req_rd),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_done(req_done),
    .m_rd_req(m_rd_req),
    .m_wr_req(m_wr_req),
    .m_addr(m_addr),
    .m_done(m_done),
    .grant_valid(grant_valid),
    .grant_id(grant_id),
    .timeout_err(timeout_err),
    .timeout_id(timeout_id),
    .err_clr(err_clr)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [31:0] a0;
    logic        md;
    logic        ec;
    logic [3:0]  dn;
    logic        mrd;
    logic        mwr;
    logic [31:0] ma;
    logic        gv;
    logic [1:0]  gid;
    logic        te;
  } vec_t;

  vec_t tbl[$];

  task automatic add(
    input logic rst, input logic [3:0] rd, input logic [3:0] wr,
    input logic [31:0] va0, input logic md, input logic ec,
    input logic [3:0] dn, input logic mrd, input logic mwr,
    input logic [31:0] ma, input logic gv, input logic [1:0] gid,
    input logic te);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.a0 = va0;
    v.md = md; v.ec = ec; v.dn = dn; v.mrd = mrd;
    v.mwr = mwr; v.ma = ma; v.gv = gv; v.gid = gid; v.te = te;
    tbl.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Caller is just after a rising edge; returns at the falling edge
  // of the first cycle with grant_valid high.
  task automatic wait_gv(output int gap, output logic ok);
    gap = 0;
    ok  = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (grant_valid) begin
        ok = 1'b1;
        return;
      end
      gap++;
      next();
    end
  endtask

  logic [41:0] act;
  logic [41:0] exp;
  int          gap;
  logic        ok;
  int          cnt;
  logic        dbad;
  logic [1:0]  order [6];

  initial begin
    reset = 1'b1; req_rd = '0; req_wr = '0; a0 = '0;
    m_done = 1'b0; err_clr = 1'b0;
    order = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};

    // rst rd wr a0 md ec | dn mrd mwr maddr gv gid te
    add(1, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 0, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 0, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 1, 0, A2,    1, 2, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 1, 0, A2,    1, 2, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 1, 0, A2,    1, 2, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 1, 0, A2,    1, 2, 0);
    add(0, 4'h4, 4'h0, 0,     1, 0, 4'h4, 1, 0, A2,    1, 2, 0);
    add(0, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 2, 0);
    add(0, 4'h0, 4'h0, 0,     1, 0, 4'h0, 0, 0, 0,     0, 2, 0);
    add(0, 4'h2, 4'h2, 0,     0, 0, 4'h0, 0, 0, 0,     0, 2, 0);
    add(0, 4'h2, 4'h2, 0,     1, 0, 4'h2, 1, 0, A1,    1, 1, 0);
    add(0, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 1, 0);
    add(0, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 1, 0);
    add(0, 4'h0, 4'h1, 32'h100, 0, 0, 4'h0, 0, 0, 0,   0, 1, 0);
    add(0, 4'h0, 4'h1, 32'h200, 0, 0, 4'h0, 0, 1, 32'h100, 1, 0, 0);
    add(0, 4'h0, 4'h1, 32'h200, 1, 0, 4'h1, 0, 1, 32'h100, 1, 0, 0);
    add(0, 4'h0, 4'h0, 32'h200, 0, 0, 4'h0, 0, 0, 0,   0, 0, 0);
    add(0, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 0, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 0, 0);
    add(1, 4'h4, 4'h0, 0,     0, 0, 4'h0, 1, 0, A2,    1, 2, 0);
    add(0, 4'h6, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 0, 0);
    add(0, 4'h6, 4'h0, 0,     1, 0, 4'h2, 1, 0, A1,    1, 1, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 1, 0);
    add(0, 4'h4, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 1, 0);
    add(0, 4'h4, 4'h0, 0,     1, 0, 4'h4, 1, 0, A2,    1, 2, 0);
    add(0, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 2, 0);
    add(0, 4'h0, 4'h0, 0,     0, 0, 4'h0, 0, 0, 0,     0, 2, 0);

    next();
    next();

    for (int r = 0; r < tbl.size(); r++) begin
      reset = tbl[r].rst; req_rd = tbl[r].rd; req_wr = tbl[r].wr;
      a0 = tbl[r].a0; m_done = tbl[r].md; err_clr = tbl[r].ec;
      @(negedge clk);
      act = {req_done, m_rd_req, m_wr_req, m_addr,
             grant_valid, grant_id, timeout_err};
      exp = {tbl[r].dn, tbl[r].mrd, tbl[r].mwr, tbl[r].ma,
             tbl[r].gv, tbl[r].gid, tbl[r].te};
      check($sformatf("row%0d", r), 64'(act), 64'(exp));
      next();
    end

    // Round robin over engines 0,1,3 with 3-cycle bursts.
    reset = 1'b1; req_rd = '0; req_wr = '0; m_done = 1'b0;
    next();
    reset = 1'b0; req_wr = 4'b1011;
    for (int b = 0; b < 6; b++) begin
      wait_gv(gap, ok);
      check($sformatf("rr%0d_wait", b), 64'(ok), 64'd1);
      if (b > 0) check($sformatf("rr%0d_gap", b), 64'(gap), 64'd2);
      check($sformatf("rr%0d_gid", b), 64'(grant_id), 64'(order[b]));
      next();
      next();
      m_done = 1'b1;
      @(negedge clk);
      check($sformatf("rr%0d_done", b), 64'(req_done),
            64'(4'b0001 << order[b]));
      next();
      m_done = 1'b0;
    end
    req_wr = '0;
    next();

    // Watchdog: engine 3 never completes; err_clr held to show set wins.
    err_clr = 1'b1; req_rd = 4'b1000;
    wait_gv(gap, ok);
    check("wd_wait", 64'(ok), 64'd1);
    check("wd_gid", 64'(grant_id), 64'd3);
    cnt = 0;
    dbad = 1'b0;
    while (grant_valid && cnt < 40) begin
      cnt++;
      if (req_done != 4'b0) dbad = 1'b1;
      next();
      @(negedge clk);
    end
    err_clr = 1'b0;
    check("wd_busy_len", 64'(cnt), 64'd16);
    check("wd_no_done", 64'(dbad), 64'd0);
    check("wd_err", 64'(timeout_err), 64'd1);
    check("wd_id", 64'(timeout_id), 64'd3);

    // Re-grant of engine 3; clear error, then m_done in the last cycle.
    next();
    wait_gv(gap, ok);
    check("wd2_wait", 64'(ok), 64'd1);
    check("wd2_gid", 64'(grant_id), 64'd3);
    check("wd2_err_held", 64'(timeout_err), 64'd1);
    err_clr = 1'b1;
    dbad = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      next();
      err_clr = 1'b0;
      m_done = (k == 16);
      @(negedge clk);
      if (!grant_valid) dbad = 1'b1;
      if (k == 2) check("wd2_err_clr", 64'(timeout_err), 64'd0);
      if (k == 16) check("wd2_done", 64'(req_done), 64'h8);
    end
    check("wd2_busy_held", 64'(dbad), 64'd0);
    next();
    m_done = 1'b0;
    req_rd = '0;
    @(negedge clk);
    check("wd2_release",
          64'({grant_valid, timeout_err, req_done}), 64'd0);
    next();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hline_axi_arbiter.md
Name: hline_axi_arbiter

Overview:
- Round-robin arbiter that shares one AXI master port between NREQ horizontal-line z-buffer engines.
- Each engine holds a level read or write request with a stable address until it sees its done pulse.
- The arbiter grants one engine at a time and holds the grant for the whole burst.
- It routes the bus completion back to the granted engine only, and has a watchdog that flags hung bursts.

Parameters:
- NREQ, 4, number of requesting engines (2..8).
- IDW, 2, width of the grant id; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 4096, maximum cycles in BUSY before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- req_rd  in  NREQ  per-engine read-burst request (level).
- req_wr  in  NREQ  per-engine write-burst request (level).
- req_addr  in  NREQ*32  per-engine burst address; engine i uses bits [32i+31:32i].
- req_done  out  NREQ  one-cycle completion pulse to the granted engine.
- m_rd_req  out  1  read request to the AXI master.
- m_wr_req  out  1  write request to the AXI master.
- m_addr  out  32  burst address to the AXI master.
- m_done  in  1  AXI master burst-complete pulse.
- grant_valid  out  1  high while a burst is owned (BUSY).
- grant_id  out  IDW  index of the owning engine; used to steer FIFO muxes.
- timeout_err  out  1  sticky watchdog error flag.
- timeout_id  out  IDW  owner id captured at the most recent timeout.
- err_clr  in  1  clears timeout_err.

Behaviour:
- Reset: state IDLE, RR pointer 0, watchdog counter 0. All outputs are 0, including timeout_err and timeout_id. Reset mid-burst abandons the burst silently.
- Requesting: engine i is requesting when req_rd[i] or req_wr[i] is high. If both are high, the burst is a read.
- States: IDLE, BUSY, RELEASE.
- IDLE: if any engine is requesting, select the first requesting index at or after the RR pointer, wrapping modulo NREQ. In the same edge:
  - latch owner id, direction and address;
  - set RR pointer = (owner+1) mod NREQ;
  - go to BUSY.
- IDLE with no request: stay in IDLE.
- Grant latency: 1 cycle from request visible in IDLE to m_*_req high.
- BUSY outputs: m_rd_req or m_wr_req (per latched direction) = 1; m_addr = latched address; grant_valid = 1; grant_id = owner.
- Address stability: m_addr and direction are held from the latch even if the engine changes its inputs.
- Dropped request: if the owner drops its request during BUSY, the burst continues; AXI bursts are not abortable.
- BUSY completion: m_done = 1 drives req_done[owner] = 1 combinationally in that cycle; next state is RELEASE.
- BUSY watchdog: the counter increments each BUSY cycle.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without m_done: set timeout_err, capture timeout_id = owner, go to RELEASE.
  - No req_done is issued; the engine keeps requesting and is re-arbitrated.
  - Simultaneous m_done and timeout: m_done wins, no error.
- RELEASE: exactly one cycle with all m_* requests 0, grant_valid 0 and counter cleared. This gives the engine one cycle to advance its state before re-arbitration. Next state is IDLE.
- Back-to-back: the same engine can be re-granted only if no other engine is requesting (RR fairness). Minimum gap between bursts is 2 cycles (RELEASE plus IDLE).
- m_done outside BUSY: ignored, and req_done stays 0.
- Error register: err_clr clears timeout_err next cycle. If err_clr coincides with a new timeout, set wins.
- Idle outputs: req_done = 0 in every cycle except the BUSY completion cycle. grant_id holds its last value when grant_valid = 0.
- Width rules: the watchdog counter is 32 bits. Requester indices >= NREQ never occur.

Test Plan:
- Single read: after reset, req_rd[2]=1, req_addr[2]=0x1000_0400, m_done 5 cycles after grant -> m_rd_req=1 and m_addr=0x1000_0400 one cycle after request; grant_id=2; req_done[2] pulses in the m_done cycle only; RELEASE cycle shows m_rd_req=0.
- Round robin: req_wr on engines 0,1,3 held continuously, each burst done in 3 cycles -> grant order 0,1,3,0,1,3 with 2-cycle gaps.
- Rd+wr conflict: engine 1 with req_rd=req_wr=1 -> m_rd_req=1 and m_wr_req=0.
- Address hold: engine 0 changes req_addr[0] from 0x100 to 0x200 mid-BUSY -> m_addr stays 0x100 until RELEASE.
- Watchdog: TIMEOUT=16, engine 3 granted, no m_done -> after 16 BUSY cycles timeout_err=1, timeout_id=3, no req_done; engine 3 is re-granted later. err_clr=1 -> timeout_err=0 next cycle.
- Edge cases: m_done in IDLE -> no req_done. reset asserted during BUSY -> next cycle all outputs 0, and a first request from engine 1 is granted before engine 2 (pointer restarts at 0).
